// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter sharing the single-master interconnect among
//            NumofMaster requesters. Grants one master at a time, drives the
//            master-side mux select and holds the grant until the owner's
//            transfer completes, the owner withdraws, or the hold watchdog
//            expires.
// Ports    : clk_i      - clock, rising edge
//            rst_i      - asynchronous reset, active-high
//            req_i      - per-master level request
//            done_i     - owner's transfer completed this cycle
//            gnt_o      - registered one-hot grant (or zero)
//            mux_sel_o  - registered index of current / last owner
//            busy_o     - any grant active
//            timeout_o  - one-cycle pulse after a watchdog revocation
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int NumofMaster   = 2,
  parameter int TimeoutCycles = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumofMaster-1:0]         req_i,
  input  logic                           done_i,
  output logic [NumofMaster-1:0]         gnt_o,
  output logic [$clog2(NumofMaster)-1:0] mux_sel_o,
  output logic                           busy_o,
  output logic                           timeout_o
);

  localparam int MuxWidth = $clog2(NumofMaster);
  localparam int CntWidth = $clog2(TimeoutCycles + 1);
  // A disabled watchdog would give a zero-width counter; keep one bit.
  localparam int CntW     = (CntWidth < 1) ? 1 : CntWidth;

  localparam logic [CntW-1:0]        CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
  localparam logic [MuxWidth:0]      NumW    = (MuxWidth + 1)'(NumofMaster);
  localparam logic [MuxWidth-1:0]    LastIdx = MuxWidth'(NumofMaster - 1);
  localparam logic [NumofMaster-1:0] OneLsb  = NumofMaster'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t                  state, state_n;
  logic [MuxWidth-1:0]     ptr, ptr_n;
  logic [CntW-1:0]         cnt, cnt_n;
  logic [NumofMaster-1:0]  gnt_n;
  logic [MuxWidth-1:0]     sel_n;
  logic                    timeout_n;

  logic [NumofMaster-1:0]  owner_oh;
  logic                    owner_req;
  logic                    wd_hit;
  logic                    release_own;
  logic                    wd_release;
  logic [NumofMaster-1:0]  arb_req;

  logic                    found;
  logic [MuxWidth-1:0]     winner;
  logic [MuxWidth:0]       sum;
  logic [MuxWidth-1:0]     idx;

  // In OWN the grant is always onehot(mux_sel_o), so mux_sel_o names the owner.
  assign owner_oh    = OneLsb << mux_sel_o;
  assign owner_req   = req_i[mux_sel_o];
  assign wd_hit      = (TimeoutCycles != 0) && (cnt == CntLast);
  assign release_own = (state == OWN) && (done_i || !owner_req || wd_hit);
  // Watchdog only counts as the cause when neither done nor withdrawal applies.
  assign wd_release  = (state == OWN) && !done_i && owner_req && wd_hit;
  assign arb_req     = wd_release ? (req_i & ~owner_oh) : req_i;

  // Round-robin search starting at ptr; index wraps modulo NumofMaster.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < NumofMaster; i++) begin
      sum = {1'b0, ptr} + (MuxWidth + 1)'(i);
      if (sum >= NumW) begin
        sum = sum - NumW;
      end
      idx = sum[MuxWidth-1:0];
      if (!found && arb_req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    gnt_n     = gnt_o;
    sel_n     = mux_sel_o;
    timeout_n = 1'b0;

    if ((state == IDLE) || release_own) begin
      timeout_n = wd_release;
      if (found) begin
        state_n = OWN;
        gnt_n   = OneLsb << winner;
        sel_n   = winner;
        cnt_n   = '0;
        ptr_n   = (winner == LastIdx) ? '0 : winner + 1'b1;
      end else begin
        // mux_sel_o deliberately keeps the last owner.
        state_n = IDLE;
        gnt_n   = '0;
      end
    end else if (cnt != '1) begin
      cnt_n = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt_o     <= '0;
      mux_sel_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      gnt_o     <= gnt_n;
      mux_sel_o <= sel_n;
      timeout_o <= timeout_n;
    end
  end

  assign busy_o = |gnt_o;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter (3 masters, 4-cycle watchdog):
//            directed vector table, mid-grant reset sequence and randomized
//            traffic compared against a behavioural round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int N  = 3;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic [N-1:0] gnt;
  logic [1:0]   sel;
  logic         busy;
  logic         tout;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.NumofMaster(N), .TimeoutCycles(TO)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .done_i    (done),
    .gnt_o     (gnt),
    .mux_sel_o (sel),
    .busy_o    (busy),
    .timeout_o (tout)
  );

  always #5 clk = ~clk;

  // Behavioural model: owner index (-1 when idle), cycles held, pointer.
  int m_owner, m_sel, m_ptr, m_held;
  bit m_to;

  task automatic model_reset();
    m_owner = -1; m_sel = 0; m_ptr = 0; m_held = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic d);
    bit arb = 0;
    bit wd  = 0;
    int win = -1;
    m_to = 0;
    if (m_owner < 0) arb = 1;
    else if (d || !r[m_owner]) arb = 1;
    else if (m_held == TO - 1) begin arb = 1; wd = 1; end
    else m_held = m_held + 1;
    if (arb) begin
      for (int i = 0; i < N; i++) begin
        int c = (m_ptr + i) % N;
        if (win < 0 && r[c] && !(wd && c == m_owner)) win = c;
      end
      m_to = wd;
      if (win >= 0) begin
        m_owner = win; m_sel = win; m_held = 0; m_ptr = (win + 1) % N;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  typedef struct {
    logic [2:0] req;
    logic       done;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       to;
  } vec_t;

  vec_t tbl[26];

  initial begin
    // Reset / first grant / rotation
    tbl[0]  = '{3'b001, 1'b0, 3'b001, 2'd0, 1'b0};
    tbl[1]  = '{3'b111, 1'b0, 3'b001, 2'd0, 1'b0};
    tbl[2]  = '{3'b111, 1'b1, 3'b010, 2'd1, 1'b0};
    tbl[3]  = '{3'b111, 1'b0, 3'b010, 2'd1, 1'b0};
    tbl[4]  = '{3'b111, 1'b1, 3'b100, 2'd2, 1'b0};
    tbl[5]  = '{3'b111, 1'b0, 3'b100, 2'd2, 1'b0};
    tbl[6]  = '{3'b111, 1'b1, 3'b001, 2'd0, 1'b0};
    tbl[7]  = '{3'b111, 1'b0, 3'b001, 2'd0, 1'b0};
    tbl[8]  = '{3'b111, 1'b1, 3'b010, 2'd1, 1'b0};
    // Watchdog hands owner 1 over to master 0
    tbl[9]  = '{3'b011, 1'b0, 3'b010, 2'd1, 1'b0};
    tbl[10] = '{3'b011, 1'b0, 3'b010, 2'd1, 1'b0};
    tbl[11] = '{3'b011, 1'b0, 3'b010, 2'd1, 1'b0};
    tbl[12] = '{3'b011, 1'b0, 3'b001, 2'd0, 1'b1};
    // Withdrawal handover, then watchdog with no alternative -> idle
    tbl[13] = '{3'b010, 1'b0, 3'b010, 2'd1, 1'b0};
    tbl[14] = '{3'b010, 1'b0, 3'b010, 2'd1, 1'b0};
    tbl[15] = '{3'b010, 1'b0, 3'b010, 2'd1, 1'b0};
    tbl[16] = '{3'b010, 1'b0, 3'b010, 2'd1, 1'b0};
    tbl[17] = '{3'b010, 1'b0, 3'b000, 2'd1, 1'b1};
    // Owner 2 withdraws, pointer wraps to 0
    tbl[18] = '{3'b100, 1'b0, 3'b100, 2'd2, 1'b0};
    tbl[19] = '{3'b000, 1'b0, 3'b000, 2'd2, 1'b0};
    tbl[20] = '{3'b101, 1'b0, 3'b001, 2'd0, 1'b0};
    // done coincident with watchdog expiry: no mask, no timeout pulse
    tbl[21] = '{3'b001, 1'b0, 3'b001, 2'd0, 1'b0};
    tbl[22] = '{3'b001, 1'b0, 3'b001, 2'd0, 1'b0};
    tbl[23] = '{3'b001, 1'b0, 3'b001, 2'd0, 1'b0};
    tbl[24] = '{3'b001, 1'b1, 3'b001, 2'd0, 1'b0};
    tbl[25] = '{3'b011, 1'b1, 3'b010, 2'd1, 1'b0};

    model_reset();
    #12;
    chk("rst_gnt",  32'(gnt),  32'd0);
    chk("rst_sel",  32'(sel),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_to",   32'(tout), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      cycle(tbl[i].req, tbl[i].done);
      chk($sformatf("vec%0d_gnt", i),  32'(gnt),  32'(tbl[i].gnt));
      chk($sformatf("vec%0d_sel", i),  32'(sel),  32'(tbl[i].sel));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(|tbl[i].gnt));
      chk($sformatf("vec%0d_to", i),   32'(tout), 32'(tbl[i].to));
    end

    // Asynchronous reset between edges while master 1 owns the bus
    req = 3'b010;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gnt",  32'(gnt),  32'd0);
    chk("arst_sel",  32'(sel),  32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    #2;
    rst = 1'b0;
    model_reset();
    cycle(3'b110, 1'b0);
    chk("post_rst_gnt", 32'(gnt), 32'b010);
    chk("post_rst_sel", 32'(sel), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      logic         d;
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      d = ($urandom_range(0, 3) == 0);
      cycle(r, d);
      chk("rnd_gnt",  32'(gnt),  (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("rnd_sel",  32'(sel),  32'(m_sel));
      chk("rnd_busy", 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
      chk("rnd_to",   32'(tout), 32'(m_to));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
